pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the pipeline-register enables of the 5-stage MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards and inserts a bubble.
- Flushes on a taken branch or jump.
- Freezes the whole pipe while data memory is not ready.
- Halts on memory timeout.
- Keeps saturating stall/flush statistics.
- Sits beside the datapath and drives every pipeline register's enable/flush input instead of the tie-to-1 enables used today.

Parameters:
- MEM_TIMEOUT, 16, maximum consecutive MEM_WAIT cycles before error.
- CNT_W, 16, width of statistic counters.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- id_rs  input  5  rs field of instruction in ID
- id_rt  input  5  rt field of instruction in ID
- id_uses_rt  input  1  ID instruction reads rt as a source
- idex_mem_read  input  1  instruction in EX is a load
- idex_rt  input  5  destination rt of instruction in EX
- ex_branch_taken  input  1  branch/jump resolved taken in EX
- mem_req  input  1  MEM stage accessing data memory this cycle
- mem_ready  input  1  data memory completes access this cycle
- pc_enable  output  1  PC load enable
- ifid_enable  output  1  IF/ID register enable
- ifid_flush  output  1  IF/ID synchronous clear (NOP)
- idex_enable  output  1  ID/EX register enable
- idex_bubble  output  1  ID/EX loads zero control bits (RegWrite=0, MemtoReg=0, MemRead=0)
- exmem_enable  output  1  EX/MEM register enable
- memwb_enable  output  1  MEM/WB register enable
- halted  output  1  sticky memory-timeout error
- stall_count  output  CNT_W  cycles with pc_enable=0 (saturating)
- flush_count  output  CNT_W  taken-branch flushes (saturating)

Behaviour:
- States: RUN, MEM_WAIT, HALT. Asynchronous reset (reset=0) -> RUN; wait counter, stall_count, flush_count = 0; halted = 0.
- While reset=0, outputs are forced: all enables 0, ifid_flush=1, idex_bubble=1.
- Outputs are a combinational (Mealy) decode of state and current inputs. There is zero-cycle latency from hazard to stall.
- Default output set: all enables 1; ifid_flush=0; idex_bubble=0.
- load_use = idex_mem_read & (idex_rt!=0) & ((idex_rt==id_rs) | (id_uses_rt & idex_rt==id_rt)).
- RUN, priority high->low:
  1. mem_req & !mem_ready: all five enables = 0. Next state MEM_WAIT; wait counter <= 1.
  2. ex_branch_taken: ifid_flush=1, idex_bubble=1, pc_enable=1 so the target loads. flush_count++.
  3. load_use: pc_enable=0, ifid_enable=0, idex_bubble=1. Remains in RUN; the hazard clears next cycle because the bubble drops idex_mem_read.
- Branch and load_use together: the branch wins and there is no stall, because the ID instruction is being flushed.
- MEM_WAIT:
  - mem_ready=0: all enables 0. Wait counter increments. When it reaches MEM_TIMEOUT, next state is HALT.
  - mem_ready=1: evaluate exactly as RUN rules 2-3 with rule 1 skipped. Next state is RUN.
  - Upstream inputs are stable while frozen, so a pending branch or load-use applies on the exit cycle.
  - No flush or bubble is asserted while frozen.
- HALT: all enables 0, halted=1. Left only by reset.
- stall_count increments every cycle pc_enable=0 outside reset, including HALT. It saturates at all-ones and never wraps. flush_count saturates identically.
- mem_ready=1 with mem_req=0 is ignored in RUN.
- Reset asserted mid-MEM_WAIT: immediate return to RUN; counters cleared.

Decomposition:
- Package pipeline_ctrl_pkg:
  - state enum {RUN, MEM_WAIT, HALT}
  - constant REG_ZERO = 5'd0
  - localparam REG_ADDR_W = 5
- Sub-module hazard_detect: purely combinational load_use comparator. Its inputs are id_rs, id_rt, id_uses_rt, idex_mem_read, idex_rt, and its output is load_use.
- FSM, wait counter, and statistics stay in the top module.

Test Plan:
- Load-use: idex_mem_read=1, idex_rt=5, id_rs=5 for one cycle, then idex_mem_read=0 -> that cycle pc_enable=0, ifid_enable=0, idex_bubble=1; next cycle all enables 1; stall_count=1.
- Register-zero exemption: idex_mem_read=1, idex_rt=0, id_rs=0 -> no stall, stall_count stays 0.
- Branch with coincident load-use: ex_branch_taken=1 and load_use=1 -> ifid_flush=1, idex_bubble=1, pc_enable=1; flush_count=1; stall_count=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> all enables 0 for 3 cycles, 1 on the 4th; stall_count=3; state back to RUN.
- Timeout: mem_req=1, mem_ready=0 held for MEM_TIMEOUT=16 cycles -> halted=1 from cycle 17 onward, enables stay 0 even after mem_ready=1; reset low clears halted, counters 0.
- Saturation and mid-wait reset: CNT_W=4 with 20 stall cycles -> stall_count holds 15; pulsing reset low during MEM_WAIT -> state RUN and counters 0 asynchronously.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    HALT
  } state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the datapath and the hazard controller: hazard sources
// flowing in, pipeline register enables and statistics flowing out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipeline_ctrl_pkg::*;

  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_uses_rt;
  logic                  idex_mem_read;
  logic [REG_ADDR_W-1:0] idex_rt;
  logic                  ex_branch_taken;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  pc_enable;
  logic                  ifid_enable;
  logic                  ifid_flush;
  logic                  idex_enable;
  logic                  idex_bubble;
  logic                  exmem_enable;
  logic                  memwb_enable;
  logic                  halted;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;

  // Controller side: observes hazards, drives enables.
  modport master (
    input  id_rs, id_rt, id_uses_rt, idex_mem_read, idex_rt,
           ex_branch_taken, mem_req, mem_ready,
    output pc_enable, ifid_enable, ifid_flush, idex_enable, idex_bubble,
           exmem_enable, memwb_enable, halted, stall_count, flush_count
  );

  // Datapath side: reports hazards, obeys enables.
  modport slave (
    output id_rs, id_rt, id_uses_rt, idex_mem_read, idex_rt,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_enable, ifid_enable, ifid_flush, idex_enable, idex_bubble,
           exmem_enable, memwb_enable, halted, stall_count, flush_count
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination is a source of the
// instruction in ID. Register zero never creates a dependency.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rt,
  output logic                  load_use
);

  // The rt match only counts when the ID instruction really reads rt.
  always_comb begin
    load_use = idex_mem_read && (idex_rt != REG_ZERO) &&
               ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register enable sequencer: load-use bubbles, branch flushes,
// whole-pipe freeze on slow data memory, sticky halt on memory timeout,
// and saturating stall/flush statistics.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.master pipe
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic [WAIT_W-1:0] waitNext;
  logic [CNT_W-1:0]  stallCount_q;
  logic [CNT_W-1:0]  flushCount_q;
  logic              loadUse;
  logic              pcEn, ifidEn, idexEn, exmemEn, memwbEn;
  logic              ifidFlush, idexBubble;

  hazard_detect u_hazard_detect (
    .id_rs         (pipe.id_rs),
    .id_rt         (pipe.id_rt),
    .id_uses_rt    (pipe.id_uses_rt),
    .idex_mem_read (pipe.idex_mem_read),
    .idex_rt       (pipe.idex_rt),
    .load_use      (loadUse)
  );

  assign waitNext = waitCnt_q + 1'b1;

  // Mealy decode of state and live hazards; a branch outranks load-use since
  // the dependent ID instruction is being flushed anyway, and nothing is
  // flushed or bubbled while the pipe is frozen.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    pcEn       = 1'b1;
    ifidEn     = 1'b1;
    idexEn     = 1'b1;
    exmemEn    = 1'b1;
    memwbEn    = 1'b1;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    case (state_q)
      RUN: begin
        if (pipe.mem_req && !pipe.mem_ready) begin
          {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = 5'b00000;
          state_d   = MEM_WAIT;
          waitCnt_d = WAIT_W'(1);
        end else if (pipe.ex_branch_taken) begin
          ifidFlush  = 1'b1;
          idexBubble = 1'b1;
        end else if (loadUse) begin
          pcEn       = 1'b0;
          ifidEn     = 1'b0;
          idexBubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!pipe.mem_ready) begin
          {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = 5'b00000;
          waitCnt_d = waitNext;
          if (waitNext >= WAIT_W'(MEM_TIMEOUT)) begin
            state_d = HALT;
          end
        end else begin
          state_d = RUN;
          if (pipe.ex_branch_taken) begin
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
          end else if (loadUse) begin
            pcEn       = 1'b0;
            ifidEn     = 1'b0;
            idexBubble = 1'b1;
          end
        end
      end
      HALT: begin
        {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = 5'b00000;
      end
      default: begin
        {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = 5'b00000;
        state_d = RUN;
      end
    endcase
    if (!reset) begin
      {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = 5'b00000;
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
    end
  end

  // State, wait counter and saturating statistics; reset clears all at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      waitCnt_q    <= '0;
      stallCount_q <= '0;
      flushCount_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      if (!pcEn && (stallCount_q != {CNT_W{1'b1}})) begin
        stallCount_q <= stallCount_q + 1'b1;
      end
      if (ifidFlush && (flushCount_q != {CNT_W{1'b1}})) begin
        flushCount_q <= flushCount_q + 1'b1;
      end
    end
  end

  assign pipe.pc_enable    = pcEn;
  assign pipe.ifid_enable  = ifidEn;
  assign pipe.ifid_flush   = ifidFlush;
  assign pipe.idex_enable  = idexEn;
  assign pipe.idex_bubble  = idexBubble;
  assign pipe.exmem_enable = exmemEn;
  assign pipe.memwb_enable = memwbEn;
  assign pipe.halted       = (state_q == HALT);
  assign pipe.stall_count  = stallCount_q;
  assign pipe.flush_count  = flushCount_q;

endmodule
